// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types and defaults.
// Pixel/row typedefs are sized at the default configuration.
package jpeg_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_CHANNELS = 3;
    localparam int unsigned DEF_ROW_LEN  = 8;

    typedef logic [DEF_CHANNELS*DEF_DATA_W-1:0] pixel_t;
    typedef pixel_t row_t [DEF_ROW_LEN];

    // Width needed to count 0..2*row_len pixels across both banks.
    function automatic int unsigned fill_bits(input int unsigned row_len);
        return $clog2(2 * row_len + 1);
    endfunction

endpackage

// File: rtl/pp_bank.sv
// One ROW_LEN-entry pixel register bank with indexed write and tail padding.
// Padding writes pad_data into every entry at or above pad_start.
module pp_bank #(
    parameter int unsigned ROW_LEN = 8,
    parameter int unsigned PIX_W   = 24,
    localparam int unsigned IDX_W  = $clog2(ROW_LEN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [IDX_W-1:0]                idx,
    input  logic [PIX_W-1:0]                wdata,
    input  logic                            pad,
    input  logic [IDX_W-1:0]                pad_start,
    input  logic [PIX_W-1:0]                pad_data,
    output logic [ROW_LEN-1:0][PIX_W-1:0]   row
);

    logic [ROW_LEN-1:0][PIX_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
        end else begin
            for (int i = 0; i < ROW_LEN; i++) begin
                if (we && idx == IDX_W'(i)) begin
                    row_q[i] <= wdata;
                end else if (pad && IDX_W'(i) >= pad_start) begin
                    row_q[i] <= pad_data;
                end
            end
        end
    end

    assign row = row_q;

endmodule

// File: rtl/ycbcr_pingpong_buf.sv
// Ping-pong row buffer: serial pixels in, completed rows out under valid/ready.
// Supports partial-row flush with replication of the last written pixel.
module ycbcr_pingpong_buf
    import jpeg_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned ROW_LEN  = DEF_ROW_LEN
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CHANNELS*DATA_W-1:0]              in_data,
    input  logic                                    flush,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ROW_LEN-1:0][CHANNELS*DATA_W-1:0] out_data,
    output logic [fill_bits(ROW_LEN)-1:0]           fill_level
);

    localparam int unsigned PIX_W  = CHANNELS * DATA_W;
    localparam int unsigned IDX_W  = $clog2(ROW_LEN);
    localparam int unsigned FILL_W = fill_bits(ROW_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [PIX_W-1:0] last_pix_q;

    logic             accept, xfer, row_done, flush_act, close_row;
    logic [IDX_W-1:0] pad_start;
    logic [PIX_W-1:0] pad_data;

    logic [1:0][ROW_LEN-1:0][PIX_W-1:0] bank_row;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_data  = bank_row[rd_bank_q];
    assign fill_level = FILL_W'((int'(full_q[0]) + int'(full_q[1])) * ROW_LEN + int'(wr_idx_q));

    always_comb begin
        accept   = in_valid && in_ready;
        xfer     = out_valid && out_ready;
        row_done = accept && (wr_idx_q == LAST_IDX);
        // Flush only matters if the row would otherwise be left partially written.
        flush_act = flush && (accept ? (wr_idx_q != LAST_IDX) : (wr_idx_q != '0));
        close_row = row_done || flush_act;

        pad_start = accept ? wr_idx_q + IDX_W'(1) : wr_idx_q;
        pad_data  = accept ? in_data : last_pix_q;

        full_d = full_q;
        if (xfer) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (close_row) begin
            full_d[wr_bank_q] = 1'b1;
        end

        wr_bank_d = wr_bank_q ^ close_row;
        rd_bank_d = rd_bank_q ^ xfer;

        wr_idx_d = wr_idx_q;
        if (close_row) begin
            wr_idx_d = '0;
        end else if (accept) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            last_pix_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            if (accept) begin
                last_pix_q <= in_data;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank #(
            .ROW_LEN (ROW_LEN),
            .PIX_W   (PIX_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .we        (accept && (wr_bank_q == 1'(b))),
            .idx       (wr_idx_q),
            .wdata     (in_data),
            .pad       (flush_act && (wr_bank_q == 1'(b))),
            .pad_start (pad_start),
            .pad_data  (pad_data),
            .row       (bank_row[b])
        );
    end

endmodule

// File: tb/tb_ycbcr_pingpong_buf.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based row model (pending rows FIFO + current partial row).
module tb_ycbcr_pingpong_buf;
    import jpeg_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned CH = 3;
    localparam int unsigned L  = 8;
    localparam int unsigned PW = DW * CH;
    localparam int unsigned FW = fill_bits(L);

    typedef logic [L-1:0][PW-1:0] row_vec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    pixel_t                 in_data;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    row_vec_t               out_data;
    logic [FW-1:0]          fill_level;

    always #5 clk = ~clk;

    ycbcr_pingpong_buf #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .ROW_LEN  (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill_level (fill_level)
    );

    row_vec_t     pend[$];
    logic [PW-1:0] part[$];
    logic [PW-1:0] last_px;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        part.delete();
        last_px = '0;
    endtask

    // One clock of the abstract buffer: a row leaves, a pixel enters, rows close.
    task automatic model_step(input bit iv, input logic [PW-1:0] d, input bit fl, input bit ordy);
        bit acc;
        bit xf;
        row_vec_t r;
        acc = iv && (pend.size() < 2);
        xf  = (pend.size() > 0) && ordy;
        if (xf) void'(pend.pop_front());
        if (acc) begin
            part.push_back(d);
            last_px = d;
        end
        if (part.size() == L || (fl && part.size() > 0)) begin
            for (int i = 0; i < L; i++) r[i] = (i < part.size()) ? part[i] : last_px;
            pend.push_back(r);
            part.delete();
        end
    endtask

    task automatic check_outputs();
        check("in_ready", in_ready, pend.size() < 2);
        check("out_valid", out_valid, pend.size() > 0);
        check("fill_level", fill_level, L * pend.size() + part.size());
        if (pend.size() > 0) check("out_data", out_data, pend[0]);
    endtask

    task automatic cycle(input bit iv, input logic [PW-1:0] d, input bit fl, input bit ordy,
                         output bit acc);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        acc = iv && (pend.size() < 2);
        @(posedge clk);
        model_step(iv, d, fl, ordy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    initial begin
        bit acc;
        logic [PW-1:0] px;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b1;
        @(negedge clk);
        check_outputs();

        // Reset mid-row after 5 pixels
        for (int k = 1; k <= 5; k++) cycle(1'b1, PW'(32'h50 + k), 1'b0, 1'b0, acc);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_fill", fill_level, 0);
        check("midrst_out_data", out_data, 0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check_outputs();

        // Streaming with downstream always ready
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, PW'(k), 1'b0, 1'b1, acc);
            check("stream_in_ready", in_ready, 1);
            if (k == 8) begin
                check("stream_row0_valid", out_valid, 1);
                check("stream_row0_e0", out_data[0], 24'h000001);
                check("stream_row0_e7", out_data[7], 24'h000008);
            end
            if (k == 16) begin
                check("stream_row1_e0", out_data[0], 24'h000009);
                check("stream_row1_e7", out_data[7], 24'h000010);
            end
        end
        drain(3);

        // Backpressure: 20 pixels offered with downstream stalled
        px = 24'h000101;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, px, 1'b0, 1'b0, acc);
            if (acc) px++;
        end
        check("bp_fill", fill_level, 16);
        check("bp_in_ready", in_ready, 0);
        check("bp_held_px", px, 24'h000111);
        cycle(1'b1, px, 1'b0, 1'b1, acc);
        check("bp_in_ready_after_xfer", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, px, 1'b0, 1'b0, acc);
            if (acc) px++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        check("bp_row_after_17_e0", out_data[0], 24'h000111);
        check("bp_row_after_17_e7", out_data[7], 24'h000114);
        drain(3);

        // Flush of a 3-pixel row
        cycle(1'b1, 24'hAABBCC, 1'b0, 1'b0, acc);
        cycle(1'b1, 24'h112233, 1'b0, 1'b0, acc);
        cycle(1'b1, 24'h445566, 1'b0, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("flush_valid", out_valid, 1);
        check("flush_fill", fill_level, 8);
        check("flush_e0", out_data[0], 24'hAABBCC);
        check("flush_e1", out_data[1], 24'h112233);
        check("flush_e2", out_data[2], 24'h445566);
        check("flush_e7", out_data[7], 24'h445566);
        drain(2);

        // Flush concurrent with the 7th accept
        for (int k = 1; k <= 6; k++) cycle(1'b1, PW'(32'h700 + k), 1'b0, 1'b0, acc);
        cycle(1'b1, 24'h0F0F0F, 1'b1, 1'b0, acc);
        check("flushacc_e6", out_data[6], 24'h0F0F0F);
        check("flushacc_e7", out_data[7], 24'h0F0F0F);
        check("flushacc_fill", fill_level, 8);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        check("flushacc_one_row", out_valid, 0);
        drain(1);

        // Ping-pong edge: fill both banks, then stream with continuous drain
        for (int k = 0; k < 16; k++) cycle(1'b1, PW'(32'h900 + k), 1'b0, 1'b0, acc);
        check("pp_both_full", fill_level, 16);
        px = 24'h000A00;
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, px, 1'b0, (k % 8) == 0 || k < 2, acc);
            if (acc) px++;
        end
        drain(4);

        // Random traffic
        px = PW'($urandom);
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 9) < 7, px, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, acc);
            if (acc) px = PW'($urandom);
        end
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
